// File: rtl/reg_file_rename.sv
// Architectural register file with per-register ROB rename tags.
// Commit writes values and releases ownership on tag match; issue claims
// ownership for a ROB slot; queries return the committed value or the tag to wait on.
module reg_file_rename #(
   parameter int unsigned ROB_W = 4,
   parameter int unsigned XLEN  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rdy,
   input  logic             rollback,
   input  logic             commit_en,
   input  logic [4:0]       commit_rd,
   input  logic [XLEN-1:0]  commit_val,
   input  logic [ROB_W-1:0] commit_rob_pos,
   input  logic             issue_en,
   input  logic [4:0]       issue_rd,
   input  logic [ROB_W-1:0] issue_rob_pos,
   input  logic [4:0]       rs1_idx,
   output logic [XLEN-1:0]  rs1_val,
   output logic             rs1_busy,
   output logic [ROB_W-1:0] rs1_tag,
   input  logic [4:0]       rs2_idx,
   output logic [XLEN-1:0]  rs2_val,
   output logic             rs2_busy,
   output logic [ROB_W-1:0] rs2_tag
);

   localparam int unsigned NREG = 32;

   logic [XLEN-1:0]  regs [NREG];
   logic [ROB_W-1:0] tag  [NREG];
   logic [NREG-1:0]  busy;

   logic             commit_wr;
   logic             commit_tag_hit;
   logic             issue_wr;
   logic             byp1;
   logic             byp2;

   // Qualified write strobes; x0 is never written or renamed
   always_comb begin
      commit_wr      = commit_en && (commit_rd != 5'd0);
      commit_tag_hit = (tag[commit_rd] == commit_rob_pos);
      issue_wr       = issue_en && (issue_rd != 5'd0) && !rollback;
   end

   // Register state: commit value write, tag-matched busy clear, then issue/rollback override
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '{default: '0};
         tag  <= '{default: '0};
         busy <= '0;
      end else if (rdy) begin
         if (commit_wr) begin
            regs[commit_rd] <= commit_val;
            if (commit_tag_hit) begin
               busy[commit_rd] <= 1'b0;
            end
         end
         if (rollback) begin
            busy <= '0;
         end else if (issue_wr) begin
            busy[issue_rd] <= 1'b1;
            tag[issue_rd]  <= issue_rob_pos;
         end
      end
   end

   // Source 1 query with same-cycle commit bypass
   always_comb begin
      byp1     = rdy && commit_en && (commit_rd == rs1_idx) && (rs1_idx != 5'd0) &&
                 busy[rs1_idx] && (tag[rs1_idx] == commit_rob_pos);
      rs1_val  = byp1 ? commit_val : regs[rs1_idx];
      rs1_busy = busy[rs1_idx] && !byp1;
      rs1_tag  = tag[rs1_idx];
   end

   // Source 2 query with same-cycle commit bypass
   always_comb begin
      byp2     = rdy && commit_en && (commit_rd == rs2_idx) && (rs2_idx != 5'd0) &&
                 busy[rs2_idx] && (tag[rs2_idx] == commit_rob_pos);
      rs2_val  = byp2 ? commit_val : regs[rs2_idx];
      rs2_busy = busy[rs2_idx] && !byp2;
      rs2_tag  = tag[rs2_idx];
   end

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed bench for reg_file_rename: expected query results are queued as each
// step is driven and popped against the DUT outputs mid-cycle.
module tb_reg_file_rename;

   localparam int unsigned ROB_W = 4;
   localparam int unsigned XLEN  = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             rdy;
   logic             rollback;
   logic             commit_en;
   logic [4:0]       commit_rd;
   logic [XLEN-1:0]  commit_val;
   logic [ROB_W-1:0] commit_rob_pos;
   logic             issue_en;
   logic [4:0]       issue_rd;
   logic [ROB_W-1:0] issue_rob_pos;
   logic [4:0]       rs1_idx;
   logic [XLEN-1:0]  rs1_val;
   logic             rs1_busy;
   logic [ROB_W-1:0] rs1_tag;
   logic [4:0]       rs2_idx;
   logic [XLEN-1:0]  rs2_val;
   logic             rs2_busy;
   logic [ROB_W-1:0] rs2_tag;

   typedef struct packed {
      logic [XLEN-1:0]  val;
      logic             busy;
      logic [ROB_W-1:0] tag;
   } q_t;

   q_t    exp_q  [$];
   string name_q [$];
   int    errors = 0;
   int    checks = 0;

   reg_file_rename #(.ROB_W(ROB_W), .XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
      .commit_en(commit_en), .commit_rd(commit_rd), .commit_val(commit_val),
      .commit_rob_pos(commit_rob_pos),
      .issue_en(issue_en), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
      .rs1_idx(rs1_idx), .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
      .rs2_idx(rs2_idx), .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag)
   );

   always #5 clk = ~clk;

   task automatic idle();
      rdy = 1'b1; rollback = 1'b0;
      commit_en = 1'b0; commit_rd = 5'd0; commit_val = '0; commit_rob_pos = '0;
      issue_en = 1'b0; issue_rd = 5'd0; issue_rob_pos = '0;
   endtask

   task automatic do_commit(input logic [4:0] rd, input logic [ROB_W-1:0] pos,
                            input logic [XLEN-1:0] val);
      commit_en = 1'b1; commit_rd = rd; commit_rob_pos = pos; commit_val = val;
   endtask

   task automatic do_issue(input logic [4:0] rd, input logic [ROB_W-1:0] pos);
      issue_en = 1'b1; issue_rd = rd; issue_rob_pos = pos;
   endtask

   // Queue expectations for both query ports
   task automatic push(input string name,
                       input logic [XLEN-1:0] v1, input logic b1, input logic [ROB_W-1:0] t1,
                       input logic [XLEN-1:0] v2, input logic b2, input logic [ROB_W-1:0] t2);
      exp_q.push_back('{val: v1, busy: b1, tag: t1});
      name_q.push_back({name, "_rs1"});
      exp_q.push_back('{val: v2, busy: b2, tag: t2});
      name_q.push_back({name, "_rs2"});
   endtask

   // Let the query path settle, then pop and compare everything queued
   task automatic check();
      q_t    exp;
      q_t    obs;
      string nm;
      int    port;
      #1;
      port = 1;
      while (exp_q.size() != 0) begin
         exp = exp_q.pop_front();
         nm  = name_q.pop_front();
         obs = (port == 1) ? q_t'({rs1_val, rs1_busy, rs1_tag})
                           : q_t'({rs2_val, rs2_busy, rs2_tag});
         port = 3 - port;
         checks++;
         assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got val=%h busy=%b tag=%0d, want val=%h busy=%b tag=%0d",
                   nm, obs.val, obs.busy, obs.tag, exp.val, exp.busy, exp.tag);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; idle(); rs1_idx = 5'd5; rs2_idx = 5'd31;
      #12;
      push("reset_init", '0, 1'b0, '0, '0, 1'b0, '0); check();
      @(negedge clk); rst_n = 1'b1;

      // Issue then commit with bypass
      @(negedge clk); idle(); do_issue(5'd5, 4'd3); rs1_idx = 5'd5; rs2_idx = 5'd0;
      push("t2_issue", '0, 1'b0, 4'd0, '0, 1'b0, 4'd0); check();
      @(negedge clk); idle();
      push("t2_busy", '0, 1'b1, 4'd3, '0, 1'b0, 4'd0); check();
      @(negedge clk); idle(); do_commit(5'd5, 4'd3, 32'hDEAD); rs2_idx = 5'd5;
      push("t2_bypass", 32'hDEAD, 1'b0, 4'd3, 32'hDEAD, 1'b0, 4'd3); check();
      @(negedge clk); idle();
      push("t2_after", 32'hDEAD, 1'b0, 4'd3, 32'hDEAD, 1'b0, 4'd3); check();

      // Younger writer keeps ownership after older commit
      @(negedge clk); idle(); do_issue(5'd7, 4'd2); rs1_idx = 5'd7; rs2_idx = 5'd5;
      push("t3_iss_a", '0, 1'b0, 4'd0, 32'hDEAD, 1'b0, 4'd3); check();
      @(negedge clk); idle(); do_issue(5'd7, 4'd4);
      push("t3_iss_b", '0, 1'b1, 4'd2, 32'hDEAD, 1'b0, 4'd3); check();
      @(negedge clk); idle(); do_commit(5'd7, 4'd2, 32'd1);
      push("t3_nobyp", '0, 1'b1, 4'd4, 32'hDEAD, 1'b0, 4'd3); check();
      @(negedge clk); idle();
      push("t3_after", 32'd1, 1'b1, 4'd4, 32'hDEAD, 1'b0, 4'd3); check();

      // Same-cycle commit and issue on one register
      @(negedge clk); idle(); do_issue(5'd9, 4'd1); rs1_idx = 5'd9; rs2_idx = 5'd7;
      push("t4_iss", '0, 1'b0, 4'd0, 32'd1, 1'b1, 4'd4); check();
      @(negedge clk); idle(); do_commit(5'd9, 4'd1, 32'h99); do_issue(5'd9, 4'd6);
      push("t4_both", 32'h99, 1'b0, 4'd1, 32'd1, 1'b1, 4'd4); check();
      @(negedge clk); idle();
      push("t4_after", 32'h99, 1'b1, 4'd6, 32'd1, 1'b1, 4'd4); check();

      // Rollback with committing jalr and a dropped issue
      @(negedge clk); idle(); do_issue(5'd1, 4'd5); rs1_idx = 5'd1; rs2_idx = 5'd2;
      push("t5_iss", '0, 1'b0, 4'd0, '0, 1'b0, 4'd0); check();
      @(negedge clk); idle(); rollback = 1'b1; do_commit(5'd1, 4'd5, 32'h40); do_issue(5'd2, 4'd7);
      push("t5_rb", 32'h40, 1'b0, 4'd5, '0, 1'b0, 4'd0); check();
      @(negedge clk); idle();
      push("t5_after", 32'h40, 1'b0, 4'd5, '0, 1'b0, 4'd0); check();
      @(negedge clk); idle(); rs1_idx = 5'd7; rs2_idx = 5'd9;
      push("t5_cleared", 32'd1, 1'b0, 4'd4, 32'h99, 1'b0, 4'd6); check();

      // x0 writes/issues are ignored
      @(negedge clk); idle(); do_commit(5'd0, 4'd0, 32'hFFFF); do_issue(5'd0, 4'd3);
      rs1_idx = 5'd0; rs2_idx = 5'd0;
      push("t6_x0_wr", '0, 1'b0, 4'd0, '0, 1'b0, 4'd0); check();
      @(negedge clk); idle(); do_issue(5'd10, 4'd2);
      push("t6_x0_after", '0, 1'b0, 4'd0, '0, 1'b0, 4'd0); check();

      // rdy=0 freezes state and disables bypass
      @(negedge clk); idle(); rdy = 1'b0; rollback = 1'b1;
      do_commit(5'd10, 4'd2, 32'h1234); do_issue(5'd11, 4'd5);
      rs1_idx = 5'd10; rs2_idx = 5'd11;
      push("t6_hold", '0, 1'b1, 4'd2, '0, 1'b0, 4'd0); check();
      @(negedge clk); idle();
      push("t6_held", '0, 1'b1, 4'd2, '0, 1'b0, 4'd0); check();

      // Asynchronous reset mid-operation, no clock edge needed
      @(negedge clk); idle(); do_commit(5'd10, 4'd2, 32'h5555); do_issue(5'd12, 4'd7);
      rs1_idx = 5'd5; rs2_idx = 5'd10;
      #2 rst_n = 1'b0;
      push("t1_async", '0, 1'b0, 4'd0, '0, 1'b0, 4'd0); check();
      @(negedge clk); idle(); rst_n = 1'b1;
      push("t1_post", '0, 1'b0, 4'd0, '0, 1'b0, 4'd0); check();
      @(negedge clk); idle(); do_issue(5'd12, 4'd7); rs1_idx = 5'd12; rs2_idx = 5'd1;
      push("t1_first_iss", '0, 1'b0, 4'd0, '0, 1'b0, 4'd0); check();
      @(negedge clk); idle();
      push("t1_first_after", '0, 1'b1, 4'd7, '0, 1'b0, 4'd0); check();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
